// File: rtl/bpsk_symbol_mapper.sv
// rtl/bpsk_symbol_mapper.sv - byte FIFO, MSB-first serialiser and BPSK symbol mapper
// Feeds rrc_fir with OSR-sample symbols; drives idle 0 when no data is pending.
module bpsk_symbol_mapper #(
  parameter int OSR        = 10,
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ZERO_STUFF = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] sym_out,
  output logic                 sym_strobe,
  output logic                 busy
);

  localparam int CNT_W  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BIT_W  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]     LAST_SAMPLE = CNT_W'(OSR - 1);
  localparam logic [BIT_W-1:0]     TOP_BIT     = BIT_W'(IN_WIDTH - 1);
  localparam logic [FCNT_W-1:0]    FULL_CNT    = FCNT_W'(FIFO_DEPTH);
  localparam logic [OUT_WIDTH-1:0] SYM_POS     = OUT_WIDTH'(1);
  localparam logic [OUT_WIDTH-1:0] SYM_NEG     = '1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [IN_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]       sample_cnt_q, sample_cnt_d;
  logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
  logic [IN_WIDTH-1:0]    shift_q, shift_d;
  logic [OUT_WIDTH-1:0]   sym_out_q, sym_out_d;
  logic                   sym_strobe_q, sym_strobe_d;
  logic                   busy_q, busy_d;

  logic push;
  logic pop;
  logic fifo_empty;
  logic sample_last;
  logic bit_last;
  logic [OUT_WIDTH-1:0] cur_sym;

  assign in_ready    = (count_q != FULL_CNT);
  assign push        = in_valid && in_ready;
  assign fifo_empty  = (count_q == '0);
  assign sample_last = (sample_cnt_q == LAST_SAMPLE);
  assign bit_last    = (bit_idx_q == '0);
  assign cur_sym     = shift_q[IN_WIDTH-1] ? SYM_NEG : SYM_POS;

  assign sym_out    = sym_out_q;
  assign sym_strobe = sym_strobe_q;
  assign busy       = busy_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_RUN;
      ST_RUN:  if (sample_last && bit_last && fifo_empty) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    pop          = 1'b0;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    case (state_q)
      ST_IDLE: begin
        sample_cnt_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_idx_d = TOP_BIT;
        end
      end
      ST_RUN: begin
        if (!sample_last) begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
        end else begin
          sample_cnt_d = '0;
          if (!bit_last) begin
            shift_d   = shift_q << 1;
            bit_idx_d = bit_idx_q - BIT_W'(1);
          end else if (!fifo_empty) begin
            // Next word follows the last bit of this one with no gap
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = TOP_BIT;
          end else begin
            shift_d   = '0;
            bit_idx_d = '0;
          end
        end
      end
      default: begin
        sample_cnt_d = '0;
      end
    endcase

    sym_out_d    = '0;
    sym_strobe_d = 1'b0;
    if (state_q == ST_RUN) begin
      sym_strobe_d = (sample_cnt_q == '0);
      if ((ZERO_STUFF == 0) || (sample_cnt_q == '0)) begin
        sym_out_d = cur_sym;
      end
    end
    // Registered alongside sym_out so busy drops on the same cycle the idle symbol appears
    busy_d = (state_q == ST_RUN) || !fifo_empty;
  end

  // FIFO pointer and count logic
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      sym_out_q    <= '0;
      sym_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      sym_out_q    <= sym_out_d;
      sym_strobe_q <= sym_strobe_d;
      busy_q       <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_bpsk_symbol_mapper.sv
// tb/tb_bpsk_symbol_mapper.sv - directed self-checking bench for bpsk_symbol_mapper
module tb_bpsk_symbol_mapper;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data, in_data_b;
  logic       in_valid, in_valid_b;
  logic       in_ready, in_ready_b;
  logic [1:0] sym_out, sym_out_b;
  logic       sym_strobe, sym_strobe_b;
  logic       busy, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bpsk_symbol_mapper #(
    .OSR(10), .IN_WIDTH(8), .OUT_WIDTH(2), .FIFO_DEPTH(4), .ZERO_STUFF(0)
  ) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sym_out(sym_out), .sym_strobe(sym_strobe), .busy(busy)
  );

  bpsk_symbol_mapper #(
    .OSR(10), .IN_WIDTH(8), .OUT_WIDTH(2), .FIFO_DEPTH(4), .ZERO_STUFF(1)
  ) u_dut_zs (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .sym_out(sym_out_b), .sym_strobe(sym_strobe_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] map_bit(input logic b);
    return b ? 2'b11 : 2'b01;
  endfunction

  // Pushes n bytes (w, first byte in the top bits) with in_valid held, checking the
  // symbol stream against a FIFO-occupancy model; pops occur every 80 cycles.
  task automatic run_stream(input logic [47:0] w, input int n, input string tag);
    int  k     = 0;
    int  first = -1;
    int  cnt   = 0;
    int  s;
    bit  acc;
    bit  pop;
    bit  done  = 1'b0;
    for (int cyc = 0; cyc < n * 80 + 120 && !done; cyc++) begin
      in_valid = (k < n);
      if (k < n) in_data = w[8*(n-k)-1 -: 8];
      chk({tag, " in_ready"}, in_ready, (cnt != 4));
      acc = in_valid && (cnt != 4);
      pop = (first >= 0) && (cyc > first) && ((cyc - first - 1) % 80 == 0) &&
            ((cyc - first - 1) / 80 < n);
      tick();
      if (acc && first < 0) first = cyc;
      if (acc) k++;
      cnt = cnt + int'(acc) - int'(pop);
      if (first >= 0) begin
        s = cyc - first - 2;
        if (s < 0) begin
          chk({tag, " latency sym"}, sym_out, 2'b00);
        end else if (s < n * 80) begin
          chk({tag, " sym"}, sym_out, map_bit(w[8*n-1 - s/10]));
          chk({tag, " strobe"}, sym_strobe, (s % 10 == 0));
          chk({tag, " busy"}, busy, 1'b1);
        end else begin
          chk({tag, " end sym"}, sym_out, 2'b00);
          chk({tag, " end strobe"}, sym_strobe, 1'b0);
          chk({tag, " end busy"}, busy, 1'b0);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    chk({tag, " completed"}, done, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_valid_b = 1'b0;
    in_data_b  = 8'h00;
    #1 rst = 1'b1;
    #1;
    chk("reset sym_out", sym_out, 2'b00);
    chk("reset strobe", sym_strobe, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset in_ready", in_ready, 1'b1);
    tick();
    tick();
    chk("reset held sym_out", sym_out, 2'b00);
    #2 rst = 1'b0;
    tick();

    run_stream({40'h0, 8'hA5}, 1, "single_a5");
    repeat (3) tick();

    run_stream({32'h0, 16'h00FF}, 2, "b2b_00_ff");
    repeat (3) tick();

    run_stream(48'hC35A0FF096E1, 6, "backpressure");
    repeat (3) tick();

    // Zero-stuffed variant: 0x80 -> one -1 impulse then seven +1 impulses
    in_valid_b = 1'b1;
    in_data_b  = 8'h80;
    tick();
    in_valid_b = 1'b0;
    chk("zs accept sym", sym_out_b, 2'b00);
    tick();
    chk("zs latency sym", sym_out_b, 2'b00);
    tick();
    for (int s = 0; s < 80; s++) begin
      chk("zs sym", sym_out_b, (s % 10 != 0) ? 2'b00 : ((s == 0) ? 2'b11 : 2'b01));
      chk("zs strobe", sym_strobe_b, (s % 10 == 0));
      tick();
    end
    chk("zs end sym", sym_out_b, 2'b00);
    chk("zs end busy", busy_b, 1'b0);

    // Reset in the middle of bit 3 of word 1 with two more words queued
    in_valid = 1'b1;
    in_data  = 8'h4B;
    tick();
    in_data  = 8'hF0;
    tick();
    in_data  = 8'h0F;
    tick();
    in_valid = 1'b0;
    repeat (35) tick();
    chk("pre-reset sym", sym_out, 2'b01);
    chk("pre-reset busy", busy, 1'b1);
    chk("pre-reset in_ready", in_ready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async reset sym", sym_out, 2'b00);
    chk("async reset strobe", sym_strobe, 1'b0);
    chk("async reset busy", busy, 1'b0);
    chk("async reset in_ready", in_ready, 1'b1);
    tick();
    tick();
    #2 rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post-reset idle sym", sym_out, 2'b00);
      chk("post-reset idle busy", busy, 1'b0);
      chk("post-reset idle strobe", sym_strobe, 1'b0);
    end
    run_stream({40'h0, 8'h3C}, 1, "post_reset_3c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
